fifo_rd_arbiter: RTL and testbench
==================================

// Module: fifo_rd_arbiter
// PURPOSE
//  Shares the single FIFO read port among NUM_REQ consumers with round-robin, burst-limited grants.
//  Drives the read pointer's rd input and watches fifo_empty.
//  Returns a one-hot per-consumer data-valid strobe aligned with FIFO read data (one cycle after the read).
//  Sits between the consumer engines and the FIFO read side (read pointer + memory).
// PARAMETERS
//  NUM_REQ    4  number of consumers (2..8)
//  BURST_MAX  8  max accepted reads per grant (1..256)
//  IDX_W      2  width of owner index, $clog2(NUM_REQ)
//  CNT_W      8  beat-counter width, >= $clog2(BURST_MAX+1)
// PORTS
//  clk         in   1        single clock, all logic on posedge
//  rst         in   1        reset; synchronous and active-high
//  en          in   1        1 = new grants allowed; 0 = finish current burst, then idle
//  req_mask    in   NUM_REQ  1 = consumer eligible; masked req bits are ignored
//  req         in   NUM_REQ  level request per consumer; held while it wants data
//  fifo_empty  in   1        FIFO empty flag
//  rd          out  1        read request to read pointer: combinational, owning & req[owner] & req_mask[owner]
//  gnt         out  NUM_REQ  registered one-hot current owner, all-zero when idle
//  data_vld    out  NUM_REQ  registered one-hot: data for consumer i is on the FIFO output this cycle
//  busy        out  1        registered, 1 while in OWN
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, gnt=0, data_vld=0, busy=0, beat cnt=0, rr_last=NUM_REQ-1.
//   rd is therefore 0 the cycle after reset. Reset mid-burst aborts immediately; no further data_vld pulses.
//  Eligible request: elig = req & req_mask.
//  Accepted beat: beat = rd & ~fifo_empty. This equals the read pointer's advance condition.
//  FSM has two states:
//   IDLE: if en && |elig, pick the owner with rr_pick starting at rr_last+1 (mod NUM_REQ).
//    Next cycle: state=OWN, gnt=onehot(owner), cnt=0, rr_last=owner. Otherwise stay in IDLE.
//   OWN: cnt increments on each beat. Release occurs when either condition below holds:
//    (a) elig[owner]==0 (req dropped or owner masked);
//    (b) beat && cnt==BURST_MAX-1.
//    On release, re-arbitrate in the same cycle, with the current owner as lowest priority.
//     If en && a candidate exists: the next cycle is OWN with the new gnt, cnt=0. No bubble between owners.
//     Otherwise: the next cycle is IDLE with gnt=0.
//  Releasing on (b) while the owner still requests: the owner may be re-granted only if no other consumer is eligible.
//  fifo_empty during OWN: rd stays asserted, no beat, cnt holds. The grant is kept (no timeout).
//  en=0 during OWN: the burst continues to release. No new grant is issued after it.
//  data_vld <= gnt & {NUM_REQ{beat}}. This gives exactly one pulse per accepted read, 1-cycle latency.
//   The pulse still fires the cycle after release or after a req drop for the last beat.
//  Simultaneous (a) and (b) in one cycle: a single release, identical to (b).
//  cnt never exceeds BURST_MAX-1. The counter has no wrap-around path.
//  gnt and data_vld are always one-hot or zero (checked by assertion).
// STRUCTURE
//  Header fifo_arb_defs.vh holds these definitions:
//   localparams ST_IDLE=1'b0, ST_OWN=1'b1;
//   the default NUM_REQ/BURST_MAX values;
//   the onehot(idx) function.
//  Sub-module rr_pick (combinational) takes elig[NUM_REQ] and start idx.
//   It returns found and idx of the first set bit at or after start, wrapping.
//  Top level holds the FSM, owner index reg, rr_last, beat counter, and the data_vld register.
// TESTING
//  1. Reset: assert rst 3 cycles with req=4'b1111.
//     Required: gnt=0, rd=0, data_vld=0 throughout. The first grant after release goes to consumer 0.
//  2. Burst limit: NUM_REQ=4, BURST_MAX=8, req=4'b0001 held, fifo never empty.
//     Required: 8 data_vld[0] pulses, then release. Consumer 0 is re-granted with no idle cycle.
//  3. Round-robin: req=4'b1111, fifo full, no drops.
//     Required: gnt order 0,1,2,3,0, each exactly 8 beats, no bubble cycles between owners.
//  4. Empty stall: owner 2 with fifo_empty=1 for 5 cycles mid-burst (after 3 beats).
//     Required: rd=1, no data_vld, cnt holds at 3. After empty clears, 5 more beats, then release.
//  5. Req drop and mask: owner 1 drops req after 2 beats, consumer 3 requesting.
//     Required: gnt moves to 3 next cycle, with one final data_vld[1] pulse.
//     Then set req_mask[3]=0 mid-burst. Required: release next cycle, IDLE with gnt=0.
//  6. en=0 mid-burst: the current burst completes all 8 beats, then IDLE with req pending.
//     Raising en re-grants in 1 cycle. Raising rst mid-burst gives IDLE the next cycle.

Source files
------------

// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
// Holds FSM state encoding, default sizing and the one-hot helper.
package fifo_rd_arbiter_pkg;

    localparam int unsigned DefNumReq   = 4;
    localparam int unsigned DefBurstMax = 8;
    localparam int unsigned MaxReq      = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } state_e;

    // Callers cast the result down to their own consumer count.
    function automatic logic [MaxReq-1:0] onehot(input int unsigned idx);
        onehot = MaxReq'(1) << idx;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Consumer and FIFO read-side signals of the arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface fifo_rd_arbiter_if
    import fifo_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_mask;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] data_vld;
    logic               rd;
    logic               fifo_empty;

    modport master (
        output req,
        output req_mask,
        output fifo_empty,
        input  gnt,
        input  data_vld,
        input  rd
    );

    modport slave (
        input  req,
        input  req_mask,
        input  fifo_empty,
        output gnt,
        output data_vld,
        output rd
    );

endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after start, wrapping.
module fifo_rd_arbiter_rr_pick
    import fifo_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    int unsigned      pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos  = (32'(start_i) + i) % NUM_REQ;
            cand = IDX_W'(pos);
            if (!found_o && elig_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin, burst-limited sharing of one FIFO read port among NUM_REQ consumers.
// data_vld marks, one cycle after each accepted read, which consumer owns the FIFO output.
module fifo_rd_arbiter
    import fifo_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DefNumReq,
    parameter int unsigned BURST_MAX = DefBurstMax,
    parameter int unsigned IDX_W     = $clog2(NUM_REQ),
    parameter int unsigned CNT_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            busy,
    fifo_rd_arbiter_if.slave bus
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_last_q, rr_last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] data_vld_q, data_vld_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] elig;
    logic [IDX_W-1:0]   start;
    logic               found;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               owning;
    logic               rd;
    logic               beat;
    logic               last_beat;
    logic               release_own;

    assign elig = bus.req & bus.req_mask;

    // Starting after rr_last also makes the current owner lowest priority on release.
    assign start = (rr_last_q == IDX_W'(NUM_REQ - 1)) ? '0 : rr_last_q + IDX_W'(1);

    fifo_rd_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .elig_i  (elig),
        .start_i (start),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    assign pick_gnt    = NUM_REQ'(onehot(32'(pick_idx)));
    assign owning      = (state_q == StOwn);
    assign rd          = owning & elig[owner_q];
    assign beat        = rd & ~bus.fifo_empty;
    assign last_beat   = beat && (cnt_q == CNT_W'(BURST_MAX - 1));
    assign release_own = owning && (!elig[owner_q] || last_beat);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        data_vld_d = gnt_q & {NUM_REQ{beat}};

        unique case (state_q)
            StIdle: begin
                if (en && found) begin
                    state_d   = StOwn;
                    owner_d   = pick_idx;
                    rr_last_d = pick_idx;
                    gnt_d     = pick_gnt;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                end
            end
            StOwn: begin
                if (release_own) begin
                    // Hand over in the same cycle so there is no bubble between owners.
                    if (en && found) begin
                        owner_d   = pick_idx;
                        rr_last_d = pick_idx;
                        gnt_d     = pick_gnt;
                        cnt_d     = '0;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q      <= '0;
            gnt_q      <= '0;
            data_vld_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            data_vld_q <= data_vld_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt_q));
            assert ($onehot0(data_vld_q));
            assert (cnt_q <= CNT_W'(BURST_MAX - 1));
        end
    end

    assign bus.rd       = rd;
    assign bus.gnt      = gnt_q;
    assign bus.data_vld = data_vld_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: reset, round-robin, burst limit, empty stall,
// request drop/mask, enable gating and mid-burst reset, with hand-computed expectations.
module tb_fifo_rd_arbiter;

    localparam int unsigned NReq  = 4;
    localparam int unsigned Burst = 8;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic busy;

    int checks = 0;
    int errors = 0;

    fifo_rd_arbiter_if #(.NUM_REQ(NReq)) bus ();

    fifo_rd_arbiter #(
        .NUM_REQ   (NReq),
        .BURST_MAX (Burst),
        .IDX_W     (2),
        .CNT_W     (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .busy (busy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] v,
                           input logic r, input logic b);
        chk({tag, ".gnt"}, 8'(bus.gnt), 8'(g));
        chk({tag, ".data_vld"}, 8'(bus.data_vld), 8'(v));
        chk({tag, ".rd"}, 8'(bus.rd), 8'(r));
        chk({tag, ".busy"}, 8'(busy), 8'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev_v;

    initial begin
        rst            = 1'b1;
        en             = 1'b1;
        bus.req        = 4'b1111;
        bus.req_mask   = 4'b1111;
        bus.fifo_empty = 1'b0;

        // Reset held three cycles with all consumers requesting.
        repeat (3) begin
            tick();
            chk_all("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        end
        rst = 1'b0;
        tick();

        // Round-robin 0,1,2,3,0 with 8 beats each, back to back.
        prev_v = 4'b0000;
        for (int o = 0; o < 5; o++) begin
            for (int k = 0; k < 8; k++) begin
                chk_all("rr", oh(order[o]), (k == 0) ? prev_v : oh(order[o]), 1'b1, 1'b1);
                tick();
            end
            prev_v = oh(order[o]);
        end

        // Owner 1 just granted; drop everything and go idle.
        bus.req = 4'b0000;
        #1;
        chk_all("drop_all", 4'b0010, 4'b0001, 1'b0, 1'b1);
        tick();
        chk_all("idle0", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Burst limit with a single requester: re-granted with no idle cycle.
        bus.req = 4'b0001;
        tick();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 8; k++) begin
                chk_all("burst", 4'b0001, (b == 0 && k == 0) ? 4'b0000 : 4'b0001, 1'b1, 1'b1);
                tick();
            end
        end

        bus.req = 4'b0000;
        #1;
        chk_all("drop0", 4'b0001, 4'b0001, 1'b0, 1'b1);
        tick();
        chk_all("idle1", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Empty stall on owner 2 after three beats.
        bus.req = 4'b0100;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk_all("pre_stall", 4'b0100, (k == 0) ? 4'b0000 : 4'b0100, 1'b1, 1'b1);
            tick();
        end
        bus.req        = 4'b0101;
        bus.fifo_empty = 1'b1;
        #1;
        chk_all("stall0", 4'b0100, 4'b0100, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_all("stall", 4'b0100, 4'b0000, 1'b1, 1'b1);
            tick();
        end
        bus.fifo_empty = 1'b0;
        #1;
        chk_all("unstall", 4'b0100, 4'b0000, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_all("post_stall", 4'b0100, 4'b0100, 1'b1, 1'b1);
            tick();
        end
        chk_all("after_stall", 4'b0001, 4'b0100, 1'b1, 1'b1);

        bus.req = 4'b0000;
        #1;
        tick();
        chk_all("idle2", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Owner 1 drops after two beats, consumer 3 takes over.
        bus.req = 4'b0010;
        tick();
        chk_all("own1_b0", 4'b0010, 4'b0000, 1'b1, 1'b1);
        tick();
        chk_all("own1_b1", 4'b0010, 4'b0010, 1'b1, 1'b1);
        tick();
        bus.req = 4'b1000;
        #1;
        chk_all("own1_drop", 4'b0010, 4'b0010, 1'b0, 1'b1);
        tick();
        chk_all("own3_b0", 4'b1000, 4'b0000, 1'b1, 1'b1);
        tick();
        chk_all("own3_b1", 4'b1000, 4'b1000, 1'b1, 1'b1);
        bus.req_mask = 4'b0111;
        #1;
        chk("mask_rd", 8'(bus.rd), 8'h00);
        tick();
        chk_all("masked_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // en=0 mid-burst: burst completes, then stays idle with a request pending.
        bus.req_mask = 4'b1111;
        bus.req      = 4'b0100;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                en      = 1'b0;
                bus.req = 4'b0110;
                #1;
            end
            chk_all("en_off", 4'b0100, (k == 0) ? 4'b0000 : 4'b0100, 1'b1, 1'b1);
            tick();
        end
        chk_all("en_idle0", 4'b0000, 4'b0100, 1'b0, 1'b0);
        tick();
        chk_all("en_idle1", 4'b0000, 4'b0000, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        chk_all("en_regrant", 4'b0010, 4'b0000, 1'b1, 1'b1);
        tick();
        chk_all("pre_rst", 4'b0010, 4'b0010, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        chk_all("mid_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("post_rst", 4'b0010, 4'b0000, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
